hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline hazard and forwarding controller for the 5-stage RV32I core.
- Tracks destination-register state of the instructions in the EX, MEM and WB stages using an internal shadow pipeline.
- Detects load-use hazards and branch redirects, and generates stall, bubble and flush controls.
- Registers the 2-bit forwarding selects that drive the sel inputs of the EX-stage operand 4:1 multiplexers.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_AW  source register 1 index.
- id_rs2  in  REG_AW  source register 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination register index.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_is_link  in  1  instruction is JAL/JALR (writes PC+4).
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- ext_stall  in  1  memory-side freeze; whole pipe holds.
- stall_if_id  out  1  hold PC and IF/ID register.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  invalidate IF/ID.
- fwd_sel_a  out  2  operand-A mux select, valid during EX.
- fwd_sel_b  out  2  operand-B mux select, valid during EX.
- stall_cnt  out  CNT_W  load-use stall cycles taken.
- flush_cnt  out  CNT_W  redirects taken.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: EX/MEM/WB shadow entries invalid; fwd_sel_a/b = 2'b00; stall_if_id, bubble_ex, flush_if_id = 0; both counters = 0.
- Reset mid-operation: everything clears immediately; no pending stall survives.
- Shadow entry contents: {valid, rd, reg_write, is_load, is_link}.
- Normal advance (no ext_stall): WB <= MEM; MEM <= EX; EX <= ID fields, or an invalid entry when bubble_ex or flush applies.
- Match condition, per operand, evaluated combinationally in ID: entry valid, reg_write set, rd != 0, rd == rs, and the corresponding id_use bit set. x0 is never forwarded.
- Forwarding select, registered into fwd_sel_x on the ID->EX advance, with the younger producer taking priority:
  - Match in EX entry, not load, is_link: 2'b11 (MEM-stage PC+4).
  - Match in EX entry, not load, not link: 2'b10 (EX/MEM ALU result).
  - Match in MEM entry, load or not: 2'b01 (MEM/WB writeback value).
  - No match: 2'b00 (register file).
- Load-use hazard: id_valid, and an operand matches the EX entry with is_load.
  - Combinationally: stall_if_id = 1, bubble_ex = 1, for exactly one cycle.
  - Next cycle the load is in MEM, so the select resolves to 2'b01.
- Redirect:
  - ex_redirect = 1 gives flush_if_id = 1 and bubble_ex = 1. The ID instruction is discarded and never enters EX.
  - Redirect outranks load-use: stall_if_id = 0 when both occur together.
  - The EX entry itself still advances to MEM.
- ext_stall = 1:
  - All shadow entries, fwd_sel registers and counters hold.
  - stall_if_id = 1; bubble_ex = 0; flush_if_id = 0.
  - Hazard and redirect actions wait until ext_stall drops; ex_redirect is required to be held by EX until then.
- Latency: stall, bubble and flush are combinational, same cycle. fwd_sel changes exactly one clock after the ID-stage decision.
- Counters:
  - stall_cnt increments on each load-use stall cycle that is not overridden.
  - flush_cnt increments on each accepted redirect.
  - Both wrap modulo 2^CNT_W; no saturation.

Test Plan:
- Reset then ALU chain (addi x5 in EX; add x6,x5,x5 in ID) -> next cycle fwd_sel_a = fwd_sel_b = 2'b10, no stall.
- Load-use (lw x7 in EX; add x8,x7,x0 in ID) -> stall_if_id = bubble_ex = 1 for one cycle; stall_cnt = 1; after the advance, fwd_sel_a = 2'b01, fwd_sel_b = 2'b00.
- JAL x1 in EX, consumer reads x1 -> fwd_sel_a = 2'b11. A write to x0 with rs1 = x0 -> fwd_sel_a = 2'b00.
- Double producer: x9 written by both EX and MEM entries -> 2'b10, because the younger producer wins.
- Load-use together with ex_redirect -> flush_if_id = 1, stall_if_id = 0, flush_cnt = 1, stall_cnt unchanged.
- ext_stall held 3 cycles during a load-use -> selects and counters frozen; the single stall cycle occurs after release. Asserting rst_n low mid-sequence clears all outputs asynchronously.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage RV32I pipe: a shadow copy of the EX/MEM/WB
// destination state drives load-use stalls, redirect flushes and registered operand selects.

module hazard_fwd_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic              ex_is_link,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    output logic [1:0]        sel,
    output logic              load_hit
);
    logic ex_hit, mem_hit;

    // x0 is hardwired zero, so a producer targeting it never matches
    assign ex_hit  = use_rs && ex_valid && ex_reg_write && (ex_rd != '0) && (ex_rd == rs);
    assign mem_hit = use_rs && mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
    assign load_hit = ex_hit && ex_is_load;

    always_comb begin
        sel = 2'b00;
        if (ex_hit && !ex_is_load)
            sel = ex_is_link ? 2'b11 : 2'b10;
        else if (mem_hit)
            sel = 2'b01;
    end
endmodule

module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_is_link,
    input  logic              ex_redirect,
    input  logic              ext_stall,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
        logic              is_link;
    } shadow_t;

    shadow_t ex_q, mem_q, wb_q, id_ent;

    logic [NUM_OPS-1:0][REG_AW-1:0] op_rs;
    logic [NUM_OPS-1:0]             op_use;
    logic [NUM_OPS-1:0][1:0]        op_sel;
    logic [NUM_OPS-1:0]             op_load_hit;

    logic load_use, redirect, stall_taken;

    assign op_rs  = {id_rs2, id_rs1};
    assign op_use = {id_use_rs2, id_use_rs1};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        hazard_fwd_match #(.REG_AW(REG_AW)) u_match (
            .rs            (op_rs[i]),
            .use_rs        (op_use[i]),
            .ex_valid      (ex_q.valid),
            .ex_rd         (ex_q.rd),
            .ex_reg_write  (ex_q.reg_write),
            .ex_is_load    (ex_q.is_load),
            .ex_is_link    (ex_q.is_link),
            .mem_valid     (mem_q.valid),
            .mem_rd        (mem_q.rd),
            .mem_reg_write (mem_q.reg_write),
            .sel           (op_sel[i]),
            .load_hit      (op_load_hit[i])
        );
    end

    // A frozen pipe defers every hazard/redirect action until ext_stall drops
    assign load_use    = !ext_stall && id_valid && (|op_load_hit);
    assign redirect    = !ext_stall && ex_redirect;
    assign stall_taken = load_use && !redirect;

    assign flush_if_id = redirect;
    assign bubble_ex   = redirect || load_use;
    assign stall_if_id = ext_stall || stall_taken;

    assign id_ent = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                      is_load: id_is_load, is_link: id_is_link};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_sel_a <= 2'b00;
            fwd_sel_b <= 2'b00;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!ext_stall) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= bubble_ex ? '0 : id_ent;
            // a bubble in EX reads nothing, so park its selects on the register file
            fwd_sel_a <= bubble_ex ? 2'b00 : op_sel[0];
            fwd_sel_b <= bubble_ex ? 2'b00 : op_sel[1];
            if (stall_taken) stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect)    flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: hand-computed stall/bubble/flush, selects and counters.

module tb_hazard_fwd_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write, id_is_load, id_is_link;
    logic        ex_redirect, ext_stall;
    logic        stall_if_id, bubble_ex, flush_if_id;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [31:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_is_link(id_is_link),
        .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic st, input logic bb, input logic fl);
        chk({tag, ".stall"},  {31'd0, stall_if_id}, {31'd0, st});
        chk({tag, ".bubble"}, {31'd0, bubble_ex},   {31'd0, bb});
        chk({tag, ".flush"},  {31'd0, flush_if_id}, {31'd0, fl});
    endtask

    task automatic sel(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, ".sel_a"}, {30'd0, fwd_sel_a}, {30'd0, a});
        chk({tag, ".sel_b"}, {30'd0, fwd_sel_b}, {30'd0, b});
    endtask

    // v, rs1, rs2, use1, use2, rd, reg_write, load, link
    task automatic id_set(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic lk);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_is_load = ld; id_is_link = lk;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ex_redirect = 1'b0; ext_stall = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        ctl("reset", 0, 0, 0);
        sel("reset", 2'b00, 2'b00);
        chk("reset.stall_cnt", stall_cnt, 0);
        chk("reset.flush_cnt", flush_cnt, 0);
        #10 rst_n = 1'b1;
        tick();

        // ALU chain: addi x5 then add x6,x5,x5
        id_set(1, 0, 0, 1, 0, 5, 1, 0, 0);
        tick();
        id_set(1, 5, 5, 1, 1, 6, 1, 0, 0);
        ctl("alu", 0, 0, 0);
        tick();
        sel("alu", 2'b10, 2'b10);

        // Load-use: lw x7 then add x8,x7,x0
        id_set(1, 0, 0, 1, 0, 7, 1, 1, 0);
        tick();
        id_set(1, 7, 0, 1, 1, 8, 1, 0, 0);
        ctl("lu", 1, 1, 0);
        tick();
        chk("lu.stall_cnt", stall_cnt, 1);
        sel("lu.bubble", 2'b00, 2'b00);
        ctl("lu.resolved", 0, 0, 0);
        tick();
        sel("lu.fwd", 2'b01, 2'b00);

        // JAL x1 then consumer of x1 (which itself writes x0)
        id_set(1, 0, 0, 0, 0, 1, 1, 0, 1);
        tick();
        id_set(1, 1, 2, 1, 1, 0, 1, 0, 0);
        tick();
        sel("link", 2'b11, 2'b00);
        id_set(1, 0, 0, 1, 0, 3, 1, 0, 0);
        tick();
        sel("x0", 2'b00, 2'b00);

        // Double producer of x9: younger EX copy wins, then MEM-only hit
        id_set(1, 0, 0, 0, 0, 9, 1, 0, 0);
        tick();
        id_set(1, 0, 0, 0, 0, 9, 1, 0, 0);
        tick();
        id_set(1, 9, 9, 1, 1, 10, 1, 0, 0);
        tick();
        sel("dbl", 2'b10, 2'b10);
        id_set(1, 9, 10, 1, 1, 4, 1, 0, 0);
        tick();
        sel("mem_hit", 2'b01, 2'b10);

        // Load-use coinciding with a redirect
        id_set(1, 0, 0, 0, 0, 11, 1, 1, 0);
        tick();
        id_set(1, 11, 0, 1, 0, 12, 1, 0, 0);
        ex_redirect = 1'b1;
        #1;
        ctl("redir", 0, 1, 1);
        tick();
        ex_redirect = 1'b0;
        chk("redir.flush_cnt", flush_cnt, 1);
        chk("redir.stall_cnt", stall_cnt, 1);
        sel("redir", 2'b00, 2'b00);

        // ext_stall held 3 cycles over a load-use; lw x12 reads x11 (load now in MEM)
        id_set(1, 11, 0, 1, 0, 12, 1, 1, 0);
        tick();
        sel("es.pre", 2'b01, 2'b00);
        id_set(1, 0, 12, 0, 1, 14, 1, 0, 0);
        ext_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            ctl("es.hold", 1, 0, 0);
            tick();
            sel("es.frozen", 2'b01, 2'b00);
            chk("es.stall_cnt", stall_cnt, 1);
        end
        ext_stall = 1'b0;
        #1;
        ctl("es.release", 1, 1, 0);
        tick();
        chk("es.stall_cnt_after", stall_cnt, 2);
        chk("es.flush_cnt_after", flush_cnt, 1);
        ctl("es.resolved", 0, 0, 0);
        tick();
        sel("es.fwd", 2'b00, 2'b01);

        // Asynchronous reset in the middle of a pending load-use
        id_set(1, 14, 0, 1, 0, 13, 1, 1, 0);
        tick();
        id_set(1, 13, 0, 1, 0, 15, 1, 0, 0);
        ctl("pre_rst", 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        ctl("mid_rst", 0, 0, 0);
        sel("mid_rst", 2'b00, 2'b00);
        chk("mid_rst.stall_cnt", stall_cnt, 0);
        chk("mid_rst.flush_cnt", flush_cnt, 0);
        #10 rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
